// File: rtl/rggen_axi4lite_if.sv
// rtl/rggen_axi4lite_if.sv - AXI4-Lite channel bundle with master and slave views
interface rggen_axi4lite_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    logic                     awvalid;
    logic                     awready;
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [2:0]               awprot;
    logic                     wvalid;
    logic                     wready;
    logic [BUS_WIDTH-1:0]     wdata;
    logic [BUS_WIDTH/8-1:0]   wstrb;
    logic                     bvalid;
    logic                     bready;
    logic [1:0]               bresp;
    logic                     arvalid;
    logic                     arready;
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [2:0]               arprot;
    logic                     rvalid;
    logic                     rready;
    logic [BUS_WIDTH-1:0]     rdata;
    logic [1:0]               rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/rggen_axi4lite_command_master.sv
// rtl/rggen_axi4lite_command_master.sv - single-outstanding AXI4-Lite initiator driven by local commands
module rggen_axi4lite_command_master #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_command_valid,
    output logic                     o_command_ready,
    input  logic                     i_command_write,
    input  logic [ADDRESS_WIDTH-1:0] i_command_address,
    input  logic [BUS_WIDTH-1:0]     i_command_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_command_strobe,
    output logic                     o_response_valid,
    input  logic                     i_response_ready,
    output logic [1:0]               o_response_status,
    output logic [BUS_WIDTH-1:0]     o_response_read_data,
    rggen_axi4lite_if.master         axi4lite_if
);
    localparam int STROBE_WIDTH = BUS_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_B,
        READ,
        WAIT_R,
        RESP
    } state_e;

    state_e                   state_q, state_d;
    logic                     command_ready_q, command_ready_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [BUS_WIDTH-1:0]     write_data_q, write_data_d;
    logic [STROBE_WIDTH-1:0]  strobe_q, strobe_d;
    logic                     awvalid_q, awvalid_d;
    logic                     wvalid_q, wvalid_d;
    logic                     aw_done_q, aw_done_d;
    logic                     w_done_q, w_done_d;
    logic                     bready_q, bready_d;
    logic                     arvalid_q, arvalid_d;
    logic                     rready_q, rready_d;
    logic                     response_valid_q, response_valid_d;
    logic [1:0]               response_status_q, response_status_d;
    logic [BUS_WIDTH-1:0]     response_read_data_q, response_read_data_d;

    logic command_accept;
    logic aw_handshake;
    logic w_handshake;
    logic b_handshake;
    logic ar_handshake;
    logic r_handshake;

    always_comb begin
        command_accept = i_command_valid && command_ready_q;
        aw_handshake   = awvalid_q && axi4lite_if.awready;
        w_handshake    = wvalid_q && axi4lite_if.wready;
        b_handshake    = bready_q && axi4lite_if.bvalid;
        ar_handshake   = arvalid_q && axi4lite_if.arready;
        r_handshake    = rready_q && axi4lite_if.rvalid;
    end

    always_comb begin
        state_d              = state_q;
        command_ready_d      = command_ready_q;
        address_d            = address_q;
        write_data_d         = write_data_q;
        strobe_d             = strobe_q;
        awvalid_d            = awvalid_q;
        wvalid_d             = wvalid_q;
        aw_done_d            = aw_done_q;
        w_done_d             = w_done_q;
        bready_d             = bready_q;
        arvalid_d            = arvalid_q;
        rready_d             = rready_q;
        response_valid_d     = response_valid_q;
        response_status_d    = response_status_q;
        response_read_data_d = response_read_data_q;

        case (state_q)
            IDLE: begin
                // Ready comes up one edge after reset release and stays up while idle.
                command_ready_d = 1'b1;
                if (command_accept) begin
                    command_ready_d = 1'b0;
                    address_d       = i_command_address;
                    write_data_d    = i_command_write_data;
                    strobe_d        = i_command_strobe;
                    if (i_command_write) begin
                        state_d   = WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = READ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (aw_handshake) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_handshake) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Either channel may finish first; count a handshake landing this cycle as done.
                if ((aw_done_q || aw_handshake) && (w_done_q || w_handshake)) begin
                    state_d  = WAIT_B;
                    bready_d = 1'b1;
                end
            end
            WAIT_B: begin
                if (b_handshake) begin
                    state_d              = RESP;
                    bready_d             = 1'b0;
                    response_valid_d     = 1'b1;
                    response_status_d    = axi4lite_if.bresp;
                    response_read_data_d = '0;
                end
            end
            READ: begin
                if (ar_handshake) begin
                    state_d   = WAIT_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            WAIT_R: begin
                if (r_handshake) begin
                    state_d              = RESP;
                    rready_d             = 1'b0;
                    response_valid_d     = 1'b1;
                    response_status_d    = axi4lite_if.rresp;
                    response_read_data_d = axi4lite_if.rdata;
                end
            end
            RESP: begin
                if (i_response_ready) begin
                    state_d          = IDLE;
                    response_valid_d = 1'b0;
                    command_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q              <= IDLE;
            command_ready_q      <= 1'b0;
            address_q            <= '0;
            write_data_q         <= '0;
            strobe_q             <= '0;
            awvalid_q            <= 1'b0;
            wvalid_q             <= 1'b0;
            aw_done_q            <= 1'b0;
            w_done_q             <= 1'b0;
            bready_q             <= 1'b0;
            arvalid_q            <= 1'b0;
            rready_q             <= 1'b0;
            response_valid_q     <= 1'b0;
            response_status_q    <= 2'b00;
            response_read_data_q <= '0;
        end else begin
            state_q              <= state_d;
            command_ready_q      <= command_ready_d;
            address_q            <= address_d;
            write_data_q         <= write_data_d;
            strobe_q             <= strobe_d;
            awvalid_q            <= awvalid_d;
            wvalid_q             <= wvalid_d;
            aw_done_q            <= aw_done_d;
            w_done_q             <= w_done_d;
            bready_q             <= bready_d;
            arvalid_q            <= arvalid_d;
            rready_q             <= rready_d;
            response_valid_q     <= response_valid_d;
            response_status_q    <= response_status_d;
            response_read_data_q <= response_read_data_d;
        end
    end

    assign o_command_ready      = command_ready_q;
    assign o_response_valid     = response_valid_q;
    assign o_response_status    = response_status_q;
    assign o_response_read_data = response_read_data_q;

    // Address goes out exactly as commanded; both channels share the latched copy.
    assign axi4lite_if.awvalid = awvalid_q;
    assign axi4lite_if.awaddr  = address_q;
    assign axi4lite_if.awprot  = 3'b000;
    assign axi4lite_if.wvalid  = wvalid_q;
    assign axi4lite_if.wdata   = write_data_q;
    assign axi4lite_if.wstrb   = strobe_q;
    assign axi4lite_if.bready  = bready_q;
    assign axi4lite_if.arvalid = arvalid_q;
    assign axi4lite_if.araddr  = address_q;
    assign axi4lite_if.arprot  = 3'b000;
    assign axi4lite_if.rready  = rready_q;
endmodule

// File: tb/tb_rggen_axi4lite_command_master.sv
// tb/tb_rggen_axi4lite_command_master.sv - randomized self-checking bench against a memory reference model
module tb_rggen_axi4lite_command_master;
    localparam int AW = 16;
    localparam int BW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [BW-1:0] cmd_data = '0;
    logic [3:0]    cmd_strb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_status;
    logic [BW-1:0] rsp_data;

    rggen_axi4lite_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) axi_if ();

    rggen_axi4lite_command_master #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_command_valid      (cmd_valid),
        .o_command_ready      (cmd_ready),
        .i_command_write      (cmd_write),
        .i_command_address    (cmd_addr),
        .i_command_write_data (cmd_data),
        .i_command_strobe     (cmd_strb),
        .o_response_valid     (rsp_valid),
        .i_response_ready     (rsp_ready),
        .o_response_status    (rsp_status),
        .o_response_read_data (rsp_data),
        .axi4lite_if          (axi_if)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Slave configuration and observations
    int          aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    logic [1:0]  next_bresp = 2'b00, next_rresp = 2'b00;
    logic        force_en = 1'b0;
    logic [31:0] force_rdata = '0;
    logic [7:0]  smem [64];
    logic [AW-1:0] cap_awaddr, cap_araddr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    int aw_count = 0, w_count = 0, ar_count = 0;
    int aw_hs_cyc = -1, first_awv_cyc = -1, first_bready_cyc = -1, first_arv_cyc = -1, first_rready_cyc = -1;
    int awv_cycles = 0, wv_cycles = 0;

    // Reference model: 16 words, index = address bits [5:2]
    logic [31:0] ref_mem [16];

    initial begin
        axi_if.awready = 1'b0;
        axi_if.wready  = 1'b0;
        axi_if.bvalid  = 1'b0;
        axi_if.bresp   = 2'b00;
        axi_if.arready = 1'b0;
        axi_if.rvalid  = 1'b0;
        axi_if.rdata   = '0;
        axi_if.rresp   = 2'b00;
        for (int i = 0; i < 64; i++) smem[i] = 8'h00;
    end

    // Slave model plus protocol monitor, evaluated on the falling edge
    initial begin
        logic got_aw, got_w, got_ar, b_pend, r_pend;
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
        logic [AW-1:0] p_awaddr, p_araddr;
        logic [31:0] p_wdata;
        logic [3:0] p_wstrb;
        logic axi_act;
        int idx;
        got_aw = 0; got_w = 0; got_ar = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
        p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                got_aw = 0; got_w = 0; got_ar = 0; b_pend = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
                axi_if.awready = 0; axi_if.wready = 0; axi_if.arready = 0;
                axi_if.bvalid = 0; axi_if.rvalid = 0;
            end else begin
                if (p_awv && !p_awr) check("aw_hold", {axi_if.awvalid, axi_if.awaddr}, {1'b1, p_awaddr});
                if (p_wv && !p_wr) check("w_hold", {axi_if.wvalid, axi_if.wstrb, axi_if.wdata}, {1'b1, p_wstrb, p_wdata});
                if (p_arv && !p_arr) check("ar_hold", {axi_if.arvalid, axi_if.araddr}, {1'b1, p_araddr});
                if (axi_if.awvalid) check("awprot", axi_if.awprot, 3'b000);
                if (axi_if.arvalid) check("arprot", axi_if.arprot, 3'b000);
                axi_act = axi_if.awvalid | axi_if.wvalid | axi_if.arvalid | axi_if.bready | axi_if.rready;
                if (axi_act) check("exclusive", {rsp_valid, cmd_ready}, 2'b00);
                if (axi_if.awvalid) awv_cycles++;
                if (axi_if.wvalid) wv_cycles++;
                if (axi_if.awvalid && first_awv_cyc < 0) first_awv_cyc = cyc;
                if (axi_if.bready && first_bready_cyc < 0) first_bready_cyc = cyc;
                if (axi_if.arvalid && first_arv_cyc < 0) first_arv_cyc = cyc;
                if (axi_if.rready && first_rready_cyc < 0) first_rready_cyc = cyc;

                if (b_pend) begin axi_if.bvalid = 0; b_pend = 0; end
                if (r_pend) begin axi_if.rvalid = 0; r_pend = 0; end

                if (got_aw && got_w && !axi_if.bvalid) begin
                    if (b_cnt >= b_lat) begin
                        idx = int'(cap_awaddr[5:2]);
                        for (int b = 0; b < 4; b++)
                            if (cap_wstrb[b]) smem[idx*4+b] = cap_wdata[b*8 +: 8];
                        axi_if.bvalid = 1; axi_if.bresp = next_bresp;
                        got_aw = 0; got_w = 0; b_cnt = 0;
                    end else b_cnt++;
                end
                b_pend = axi_if.bvalid && axi_if.bready;

                axi_if.awready = axi_if.awvalid && !got_aw && (aw_cnt >= aw_lat);
                if (axi_if.awready) begin
                    cap_awaddr = axi_if.awaddr; got_aw = 1; aw_count++; aw_hs_cyc = cyc; aw_cnt = 0;
                end else if (axi_if.awvalid) aw_cnt++;

                axi_if.wready = axi_if.wvalid && !got_w && (w_cnt >= w_lat);
                if (axi_if.wready) begin
                    cap_wdata = axi_if.wdata; cap_wstrb = axi_if.wstrb; got_w = 1; w_count++; w_cnt = 0;
                end else if (axi_if.wvalid) w_cnt++;

                if (got_ar && !axi_if.rvalid) begin
                    if (r_cnt >= r_lat) begin
                        idx = int'(cap_araddr[5:2]);
                        axi_if.rdata = force_en ? force_rdata
                                     : {smem[idx*4+3], smem[idx*4+2], smem[idx*4+1], smem[idx*4]};
                        axi_if.rresp = next_rresp; axi_if.rvalid = 1;
                        got_ar = 0; r_cnt = 0;
                    end else r_cnt++;
                end
                r_pend = axi_if.rvalid && axi_if.rready;

                axi_if.arready = axi_if.arvalid && !got_ar && (ar_cnt >= ar_lat);
                if (axi_if.arready) begin
                    cap_araddr = axi_if.araddr; got_ar = 1; ar_count++; ar_cnt = 0;
                end else if (axi_if.arvalid) ar_cnt++;

                p_awv = axi_if.awvalid; p_awr = axi_if.awready; p_awaddr = axi_if.awaddr;
                p_wv = axi_if.wvalid; p_wr = axi_if.wready; p_wdata = axi_if.wdata; p_wstrb = axi_if.wstrb;
                p_arv = axi_if.arvalid; p_arr = axi_if.arready; p_araddr = axi_if.araddr;
            end
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] mask;
        mask = 0;
        for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
        return (old & ~mask) | (data & mask);
    endfunction

    function automatic logic [33:0] expected(input logic wr, input logic [AW-1:0] addr);
        if (wr) return {next_bresp, 32'h0};
        return {next_rresp, force_en ? force_rdata : ref_mem[addr[5:2]]};
    endfunction

    task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int stall, output int t_acc, output int t_rsp);
        int n, aw0, w0, ar0;
        logic [33:0] exp;
        @(negedge clk);
        aw0 = aw_count; w0 = w_count; ar0 = ar_count;
        first_awv_cyc = -1; first_bready_cyc = -1; first_arv_cyc = -1; first_rready_cyc = -1;
        awv_cycles = 0; wv_cycles = 0;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_data = data; cmd_strb = strb;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("accept_wait", n < 50, 1'b1);
        t_acc = cyc;
        exp = expected(wr, addr);
        if (wr) ref_mem[addr[5:2]] = merge(ref_mem[addr[5:2]], data, strb);
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        check("response_wait", n < 100, 1'b1);
        t_rsp = cyc;
        check("status", rsp_status, exp[33:32]);
        check("read_data", rsp_data, exp[31:0]);
        for (int i = 0; i < stall; i++) begin
            cmd_valid = 1;
            @(negedge clk);
            check("hold_resp", {rsp_valid, rsp_status, rsp_data}, {1'b1, exp});
            check("hold_no_accept", cmd_ready, 1'b0);
        end
        cmd_valid = 0;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check("resp_dropped", rsp_valid, 1'b0);
        if (wr) begin
            check("awaddr", cap_awaddr, addr);
            check("wdata_wstrb", {cap_wstrb, cap_wdata}, {strb, data});
            check("aw_w_count", {aw_count - aw0, w_count - w0, ar_count - ar0}, {32'd1, 32'd1, 32'd0});
        end else begin
            check("araddr", cap_araddr, addr);
            check("ar_count", {aw_count - aw0, ar_count - ar0}, {32'd0, 32'd1});
        end
    endtask

    initial begin
        int ta, tr, n, tx;
        logic wr;
        logic [AW-1:0] a;
        logic [31:0] d;
        logic [3:0] s;
        logic [33:0] exp;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

        #1 rst = 1;
        @(negedge clk);
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1'b0);
        check("reset_resp", {rsp_valid, rsp_status, rsp_data}, 35'h0);
        check("reset_axi_valids", {axi_if.awvalid, axi_if.wvalid, axi_if.bready, axi_if.arvalid, axi_if.rready}, 5'b0);
        check("reset_latched", {axi_if.awaddr, axi_if.wdata, axi_if.wstrb}, 52'h0);
        #1 rst = 0;
        @(negedge clk);
        check("ready_after_release", cmd_ready, 1'b1);

        // zero-wait write then read back
        run_cmd(1'b1, 16'h0000, 32'h000000A5, 4'hF, 0, ta, tr);
        check("wr_awvalid_T1", first_awv_cyc, ta + 1);
        check("wr_bready_T2", first_bready_cyc, ta + 2);
        check("wr_resp_T3", tr, ta + 3);
        run_cmd(1'b0, 16'h0000, 32'h0, 4'h0, 0, ta, tr);
        check("rd_arvalid_T1", first_arv_cyc, ta + 1);
        check("rd_rready_T2", first_rready_cyc, ta + 2);
        check("rd_resp_T3", tr, ta + 3);

        // awready late by 3 cycles, wready immediate
        aw_lat = 3;
        run_cmd(1'b1, 16'h0008, 32'h12345678, 4'h5, 0, ta, tr);
        check("wvalid_cycles", wv_cycles, 1);
        check("awvalid_cycles", awv_cycles, 4);
        check("bready_after_aw", first_bready_cyc, aw_hs_cyc + 1);
        aw_lat = 0;

        // slave-chosen data and error status
        force_en = 1; force_rdata = 32'hDEADBEEF; next_rresp = 2'b10;
        run_cmd(1'b0, 16'h0010, 32'h0, 4'h0, 5, ta, tr);
        force_en = 0; next_rresp = 2'b00;

        // reset while AW and W are both pending
        aw_lat = 6; w_lat = 6;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0020; cmd_data = 32'hCAFEF00D; cmd_strb = 4'hF;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        check("pre_reset_valids", {axi_if.awvalid, axi_if.wvalid}, 2'b11);
        #2 rst = 1;
        #1;
        check("async_reset_valids", {axi_if.awvalid, axi_if.wvalid, cmd_ready, rsp_valid}, 4'b0000);
        @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
        check("ready_after_mid_reset", cmd_ready, 1'b1);
        aw_lat = 0; w_lat = 0;

        // back-to-back commands with command valid held high
        @(negedge clk);
        rsp_ready = 1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0004; cmd_data = 32'h0BADF00D; cmd_strb = 4'hC;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("b2b_first_accept", n < 50, 1'b1);
        ref_mem[1] = merge(ref_mem[1], 32'h0BADF00D, 4'hC);
        @(negedge clk);
        cmd_write = 0; cmd_addr = 16'h0004;
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        check("b2b_first_resp", {n < 100, rsp_status}, {1'b1, 2'b00});
        tx = cyc;
        exp = expected(1'b0, 16'h0004);
        @(negedge clk);
        check("b2b_second_accept", {cmd_ready, cyc}, {1'b1, tx + 1});
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        check("b2b_second_resp", {n < 100, rsp_status, rsp_data}, {1'b1, exp});
        @(negedge clk);
        rsp_ready = 0;

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            wr = 1'($urandom_range(0, 1));
            a = 16'($urandom_range(0, 255));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); b_lat = $urandom_range(0, 3);
            ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
            next_bresp = 2'($urandom_range(0, 3)); next_rresp = 2'($urandom_range(0, 3));
            run_cmd(wr, a, d, s, $urandom_range(0, 3), ta, tr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
